// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the shift arbiter: shift op encodings and FSM states.
package shift_arbiter_pkg;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_arbiter_shift_core.sv
// shift_core: purely combinational SLL/SRL/SRA barrel shifter.
// Ports:
//   i_op     - shift op (00 SLL, 01 SRL, 10 SRA, 11 treated as SLL)
//   i_data   - operand
//   i_shamt  - shift amount
//   o_result - shifted operand
// A single logarithmic left shifter serves all ops; right shifts are done by
// bit-reversing the operand on the way in and the result on the way out, with
// the low-side fill carrying the sign bit for SRA.
module shift_core
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [1:0]         i_op,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [WIDTH-1:0]   o_result
);

    logic               w_right;
    logic               w_fill;
    logic [WIDTH-1:0]   w_data_rev;
    logic [WIDTH-1:0]   w_shift_in;
    logic [WIDTH-1:0]   w_shift_out;
    logic [WIDTH-1:0]   w_out_rev;
    logic [WIDTH-1:0]   w_stage [0:SHAMT_W];

    assign w_right = (i_op == SHIFT_SRL) || (i_op == SHIFT_SRA);
    assign w_fill  = (i_op == SHIFT_SRA) && i_data[WIDTH-1];

    for (genvar g = 0; g < WIDTH; g++) begin : g_rev
        assign w_data_rev[g] = i_data[WIDTH-1-g];
        assign w_out_rev[g]  = w_shift_out[WIDTH-1-g];
    end

    assign w_shift_in       = w_right ? w_data_rev : i_data;
    assign w_stage[SHAMT_W] = w_shift_in;

    // Largest stage first: 16, 8, 4, 2, 1 for a 32-bit datapath.
    for (genvar k = SHAMT_W - 1; k >= 0; k--) begin : g_stage
        localparam int S = 1 << k;
        assign w_stage[k] = i_shamt[k]
            ? {w_stage[k+1][WIDTH-1-S:0], {S{w_fill}}}
            : w_stage[k+1];
    end

    assign w_shift_out = w_stage[0];
    assign o_result    = w_right ? w_out_rev : w_shift_out;

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one barrel shifter between port 0
// (execute stage) and port 1 (mul/div unit).
// Ports:
//   clock, reset            - clock (rising edge), async active-high reset
//   reqN_valid/ready        - request handshake (ready is combinational)
//   reqN_op/data/shamt      - request operands
//   resN_valid/ready        - result handshake for the owning port
//   res_data                - shared result bus, zero while idle
//   flush0                  - cancels any port 0 operation, highest priority
//   busy                    - high while in EXEC or DONE
//
// state | meaning
// IDLE  | no operation held; arbitrate incoming requests
// EXEC  | operands latched; shift result registered at the next edge
// DONE  | result presented to owner; may re-arbitrate on consume
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [1:0]         req0_op,
    input  logic [WIDTH-1:0]   req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [1:0]         req1_op,
    input  logic [WIDTH-1:0]   req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               res0_valid,
    input  logic               res0_ready,
    output logic               res1_valid,
    input  logic               res1_ready,
    output logic [WIDTH-1:0]   res_data,
    input  logic               flush0,
    output logic               busy
);

    state_t             r_state;
    logic               r_owner;
    logic               r_last_grant;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_shamt;
    logic [WIDTH-1:0]   r_res_data;
    logic               r_res0_valid;
    logic               r_res1_valid;
    logic               r_busy;

    logic               w_req0_eff;
    logic               w_flush_own;
    logic               w_consume;
    logic               w_can_arb;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_grant_any;
    logic [1:0]         w_sel_op;
    logic [WIDTH-1:0]   w_sel_data;
    logic [SHAMT_W-1:0] w_sel_shamt;
    logic [WIDTH-1:0]   w_shift_res;

    shift_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift_core (
        .i_op     (r_op),
        .i_data   (r_data),
        .i_shamt  (r_shamt),
        .o_result (w_shift_res)
    );

    // A flushed port 0 never competes for the grant.
    assign w_req0_eff  = req0_valid && !flush0;
    // Flush of an in-flight port 0 op outranks completion and re-arbitration.
    assign w_flush_own = flush0 && !r_owner && (r_state != IDLE);
    assign w_consume   = (r_state == DONE) && !w_flush_own &&
                         (r_owner ? res1_ready : res0_ready);
    assign w_can_arb   = (r_state == IDLE) || w_consume;

    // On a tie the port that did not win last time is served.
    assign w_grant0    = w_can_arb && w_req0_eff && (!req1_valid || r_last_grant);
    assign w_grant1    = w_can_arb && req1_valid && (!w_req0_eff || !r_last_grant);
    assign w_grant_any = w_grant0 || w_grant1;

    assign w_sel_op    = w_grant1 ? req1_op    : req0_op;
    assign w_sel_data  = w_grant1 ? req1_data  : req0_data;
    assign w_sel_shamt = w_grant1 ? req1_shamt : req0_shamt;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign res0_valid = r_res0_valid;
    assign res1_valid = r_res1_valid;
    assign res_data   = r_res_data;
    assign busy       = r_busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op         <= SHIFT_SLL;
            r_data       <= '0;
            r_shamt      <= '0;
            r_res_data   <= '0;
            r_res0_valid <= 1'b0;
            r_res1_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_op         <= w_sel_op;
                        r_data       <= w_sel_data;
                        r_shamt      <= w_sel_shamt;
                        r_owner      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_state      <= EXEC;
                        r_busy       <= 1'b1;
                    end
                end
                EXEC: begin
                    if (w_flush_own) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_res_data <= '0;
                    end else begin
                        r_res_data   <= w_shift_res;
                        r_res0_valid <= !r_owner;
                        r_res1_valid <= r_owner;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (w_flush_own) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_res_data   <= '0;
                        r_res0_valid <= 1'b0;
                        r_res1_valid <= 1'b0;
                    end else if (w_consume) begin
                        r_res0_valid <= 1'b0;
                        r_res1_valid <= 1'b0;
                        if (w_grant_any) begin
                            r_op         <= w_sel_op;
                            r_data       <= w_sel_data;
                            r_shamt      <= w_sel_shamt;
                            r_owner      <= w_grant1;
                            r_last_grant <= w_grant1;
                            r_state      <= EXEC;
                        end else begin
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                            r_res_data <= '0;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_res_data   <= '0;
                    r_res0_valid <= 1'b0;
                    r_res1_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        res0_valid, res1_valid;
    logic        res0_ready, res1_ready;
    logic [31:0] res_data;
    logic        flush0;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_arbiter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .res0_valid (res0_valid),
        .res0_ready (res0_ready),
        .res1_valid (res1_valid),
        .res1_ready (res1_ready),
        .res_data   (res_data),
        .flush0     (flush0),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int port, input logic v, input logic [1:0] op,
                           input logic [31:0] d, input logic [4:0] sh);
        if (port == 0) begin
            req0_valid = v; req0_op = op; req0_data = d; req0_shamt = sh;
        end else begin
            req1_valid = v; req1_op = op; req1_data = d; req1_shamt = sh;
        end
    endtask

    // Issue one request from IDLE at a negedge, with the result consumed at once.
    task automatic run_op(input string tag, input int port, input logic [1:0] op,
                          input logic [31:0] d, input logic [4:0] sh, input logic [31:0] exp);
        int lat;
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        set_req(port, 1'b1, op, d, sh);
        #1;
        chk({tag, "_ready"}, (port == 0) ? req0_ready : req1_ready, 32'd1);
        @(negedge clock);
        set_req(port, 1'b0, op, d, sh);
        lat = 1;
        while (!((port == 0) ? res0_valid : res1_valid) && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd2);
        chk({tag, "_data"}, res_data, exp);
        @(negedge clock);
        chk({tag, "_consumed"}, {30'd0, res1_valid, res0_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        flush0 = 1'b0;
        res0_ready = 1'b0;
        res1_ready = 1'b0;
        set_req(0, 1'b0, 2'b00, 32'd0, 5'd0);
        set_req(1, 1'b0, 2'b00, 32'd0, 5'd0);
        #1;
        chk("rst_res_valid", {30'd0, res1_valid, res0_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single ops and shift arithmetic
        run_op("sll31", 0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        run_op("sra4",  1, 2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000);
        run_op("srl4",  1, 2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000);
        run_op("sra0",  1, 2'b10, 32'h8000_1234, 5'd0,  32'h8000_1234);
        run_op("srl0",  1, 2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        run_op("sll0",  1, 2'b00, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D);
        run_op("op11",  1, 2'b11, 32'h0000_0001, 5'd4,  32'h0000_0010);
        run_op("srapos",1, 2'b10, 32'h4000_0000, 5'd4,  32'h0400_0000);
        run_op("sllmix",1, 2'b00, 32'hF000_0001, 5'd4,  32'h0000_0010);
        run_op("srl31", 1, 2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001);
        run_op("sra31", 1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run_op("sra17", 1, 2'b10, 32'h8765_4321, 5'd17, 32'hFFFF_C3B2);

        // Round-robin: last grant was port 1, so port 0 wins first
        set_req(0, 1'b1, 2'b00, 32'h0000_0001, 5'd1);
        set_req(1, 1'b1, 2'b01, 32'h0000_0100, 5'd4);
        for (int i = 0; i < 9; i++) begin
            logic [1:0] exp_rdy;
            if (i == 7) begin
                set_req(0, 1'b0, 2'b00, 32'h0000_0001, 5'd1);
                set_req(1, 1'b0, 2'b01, 32'h0000_0100, 5'd4);
            end
            #1;
            case (i)
                0, 4:    exp_rdy = 2'b01;
                2, 6:    exp_rdy = 2'b10;
                default: exp_rdy = 2'b00;
            endcase
            chk($sformatf("rr_grant%0d", i), {30'd0, req1_ready, req0_ready}, {30'd0, exp_rdy});
            if (i == 2 || i == 6) begin
                chk($sformatf("rr_v%0d", i), {30'd0, res1_valid, res0_valid}, 32'd1);
                chk($sformatf("rr_d%0d", i), res_data, 32'h0000_0002);
            end else if (i == 4 || i == 8) begin
                chk($sformatf("rr_v%0d", i), {30'd0, res1_valid, res0_valid}, 32'd2);
                chk($sformatf("rr_d%0d", i), res_data, 32'h0000_0010);
            end
            @(negedge clock);
        end
        chk("rr_idle_busy", busy, 32'd0);

        // Backpressure on port 1 with port 0 waiting
        res1_ready = 1'b0;
        set_req(1, 1'b1, 2'b10, 32'h8000_0000, 5'd4);
        #1;
        chk("bp_grant1", req1_ready, 32'd1);
        @(negedge clock);
        set_req(1, 1'b0, 2'b10, 32'h8000_0000, 5'd4);
        set_req(0, 1'b1, 2'b00, 32'h0000_0003, 5'd2);
        #1;
        chk("bp_exec_rdy0", req0_ready, 32'd0);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_v%0d", i), res1_valid, 32'd1);
            chk($sformatf("bp_d%0d", i), res_data, 32'hF800_0000);
            chk($sformatf("bp_r%0d", i), req0_ready, 32'd0);
            @(negedge clock);
        end
        res1_ready = 1'b1;
        #1;
        chk("bp_release_rdy0", req0_ready, 32'd1);
        @(negedge clock);
        set_req(0, 1'b0, 2'b00, 32'h0000_0003, 5'd2);
        #1;
        chk("bp_res1_drop", res1_valid, 32'd0);
        @(negedge clock);
        chk("bp_p0_valid", res0_valid, 32'd1);
        chk("bp_p0_data", res_data, 32'h0000_000C);
        @(negedge clock);

        // Flush of a port 0 op in EXEC
        set_req(0, 1'b1, 2'b00, 32'h0000_0001, 5'd5);
        #1;
        chk("fl0_grant", req0_ready, 32'd1);
        @(negedge clock);
        set_req(0, 1'b0, 2'b00, 32'h0000_0001, 5'd5);
        flush0 = 1'b1;
        @(negedge clock);
        flush0 = 1'b0;
        chk("fl0_busy", busy, 32'd0);
        chk("fl0_data", res_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fl0_nores%0d", i), res0_valid, 32'd0);
            @(negedge clock);
        end

        // Same flush during a port 1 op leaves it intact
        set_req(1, 1'b1, 2'b01, 32'h8000_0000, 5'd4);
        #1;
        chk("fl1_grant", req1_ready, 32'd1);
        @(negedge clock);
        set_req(1, 1'b0, 2'b01, 32'h8000_0000, 5'd4);
        flush0 = 1'b1;
        @(negedge clock);
        chk("fl1_valid", res1_valid, 32'd1);
        chk("fl1_data", res_data, 32'h0800_0000);
        @(negedge clock);
        flush0 = 1'b0;

        // flush0 in IDLE suppresses port 0; port 1 still granted
        set_req(0, 1'b1, 2'b00, 32'h0000_0001, 5'd1);
        set_req(1, 1'b1, 2'b00, 32'h0000_0001, 5'd2);
        flush0 = 1'b1;
        #1;
        chk("flidle_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
        @(negedge clock);
        flush0 = 1'b0;
        set_req(0, 1'b0, 2'b00, 32'h0000_0001, 5'd1);
        set_req(1, 1'b0, 2'b00, 32'h0000_0001, 5'd2);
        @(negedge clock);
        chk("flidle_res", res_data, 32'h0000_0004);
        @(negedge clock);

        // Reset while DONE holds a port 0 result (last grant = 0 beforehand)
        res0_ready = 1'b0;
        set_req(0, 1'b1, 2'b00, 32'h0000_00FF, 5'd8);
        @(negedge clock);
        set_req(0, 1'b0, 2'b00, 32'h0000_00FF, 5'd8);
        @(negedge clock);
        chk("rd_valid", res0_valid, 32'd1);
        chk("rd_data", res_data, 32'h0000_FF00);
        #2;
        reset = 1'b1;
        #1;
        chk("rd_async_valid", res0_valid, 32'd0);
        chk("rd_async_data", res_data, 32'd0);
        chk("rd_async_busy", busy, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        set_req(0, 1'b1, 2'b00, 32'h0000_0001, 5'd0);
        set_req(1, 1'b1, 2'b00, 32'h0000_0001, 5'd0);
        #1;
        chk("rd_tie_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(negedge clock);
        set_req(0, 1'b0, 2'b00, 32'h0000_0001, 5'd0);
        set_req(1, 1'b0, 2'b00, 32'h0000_0001, 5'd0);
        @(negedge clock);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit barrel-shift datapath between two requesters: port 0 (execute stage) and port 1 (multiply/divide unit).
- Arbitrates round-robin, latches the winner's operands, computes SLL/SRL/SRA in a registered stage, and holds the result until the owner accepts it.
- Sits beside the ALU in the execute stage, so only one shifter instance exists in the core.

Parameters:
- WIDTH, 32, data width of operand and result.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request present.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (treated as SLL).
- req0_data  in  WIDTH  operand.
- req0_shamt  in  SHAMT_W  shift amount.
- req1_valid, req1_ready, req1_op, req1_data, req1_shamt: same as port 0, for port 1.
- res0_valid  out  1  result for port 0 is valid.
- res0_ready  in  1  port 0 accepts the result.
- res1_valid  out  1  result for port 1 is valid.
- res1_ready  in  1  port 1 accepts the result.
- res_data  out  WIDTH  shared result bus; meaningful only while a res*_valid is high.
- flush0  in  1  pipeline flush; cancels any port 0 operation.
- busy  out  1  high in EXEC or DONE.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; every output 0; res_data=0; last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Arbitrate when a request is present: a single valid request wins; if both are valid, the port not equal to last_grant wins.
  - The winner's req*_ready pulses high combinationally for one cycle.
  - Latch op/data/shamt/owner, set last_grant=owner, go to EXEC.
- EXEC:
  - shift_core computes the result from the latched operands; register it into res_data.
  - Go to DONE; the owner's res*_valid rises on the next cycle.
- DONE:
  - Owner's res*_valid=1; res_data held stable.
  - On owner res*_ready=1, the result is consumed this cycle.
  - If a request is also pending, arbitrate in the same cycle, latch, and go to EXEC (back-to-back). Otherwise go to IDLE.
- Latency: request accepted at edge T -> res*_valid high from cycle T+2.
- Throughput: one operation per 2 cycles when results are consumed immediately.
- No req*_ready is asserted in EXEC, or in DONE while the result is unconsumed.
- Shift arithmetic:
  - SLL: zero-fill.
  - SRL: zero-fill.
  - SRA: replicate data[WIDTH-1].
  - shamt=0 passes the operand unchanged. Max shamt=31 gives SLL 1 -> 0x80000000.
- flush0 (takes priority over all other events in the same cycle):
  - If owner=0 in EXEC or DONE: return to IDLE at the next edge, res0_valid is never asserted or is dropped, and no result is delivered.
  - In IDLE, flush0 suppresses a grant to port 0 that cycle; port 1 may still be granted.
  - flush0 never affects a port 1 operation.
- Only one res*_valid is high at a time. res_data returns to 0 when the FSM enters IDLE.
- Reset mid-operation: the operation is discarded and all state returns to reset values.

Decomposition:
- Shared constants file: op encodings SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10; FSM state encodings IDLE/EXEC/DONE.
- One sub-module, shift_core (purely combinational), computes result from (op, data, shamt).
  - Internally it uses a 5-stage logarithmic left-shift structure (16/8/4/2/1 stages, each selected by one shamt bit).
  - Right shifts are formed by bit-reversing input and output around it, with sign fill for SRA.
- shift_arbiter holds the FSM, the round-robin pointer, and the operand/result registers.

Test Plan:
- Single op: port 0 SLL data=0x00000001 shamt=31, res0_ready=1 -> req0_ready at T; res0_valid at T+2; res_data=0x80000000.
- SRA/SRL contrast:
  - port 1 SRA 0x80000000 shamt=4 -> 0xF8000000.
  - port 1 SRL 0x80000000 shamt=4 -> 0x08000000.
  - shamt=0 with any op returns the operand unchanged.
- Round-robin with both valid continuously and ready=1 -> grants alternate 0,1,0,1; accepts in back-to-back 2-cycle cadence.
- Backpressure: hold res1_ready=0 for 5 cycles -> res1_valid and res_data stable; req0_ready stays 0 until the cycle res1_ready=1.
- Flush:
  - flush0 in EXEC for a port 0 op -> no res0_valid; FSM returns to IDLE.
  - The same flush during a port 1 op -> port 1 result is delivered unchanged.
- Reset in DONE -> outputs 0 immediately, without waiting for a clock edge; the next tied request is granted to port 0.
